btn_step_ctrl: RTL

//  Front-end input conditioner between the board buttons/switches and the single-cycle CPU top level.
//  - Synchronises and debounces btn_in.
//  - Emits one-cycle press pulses.
//  - Generates the CPU clock-enable: free-run or single-step, chosen by the step-mode switch.
//  - Keeps a wrapping count of executed CPU cycles for the display stage.

---
 rtl/btn_step_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: sync+debounce buttons, press pulses, free-run/single-step CPU clock enable, wrapping step count
module btn_step_ctrl #(
  parameter int N_BTN     = 12,
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 5,
  parameter int STEP_BTN  = 0,
  parameter int RUN_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             step_mode,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             cpu_clk_en,
  output logic [15:0]      step_count
);
  localparam int DIV_W = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  logic [N_BTN-1:0] btn_s1, btn_s2;
  logic             mode_s1, mode_s2, mode_d;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [DIV_W-1:0] div;
  logic             toggle, div_wrap;
  assign toggle   = mode_s2 ^ mode_d;
  assign div_wrap = div == DIV_W'(RUN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_d  <= 1'b0;
    end else begin
      btn_s1  <= btn_in;
      btn_s2  <= btn_s1;
      mode_s1 <= step_mode;
      mode_s2 <= mode_s1;
      mode_d  <= mode_s2;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      btn_level <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_s2[i] == btn_level[i]) cnt[i] <= '0;
        else if (cnt[i] != CNT_W'(DB_CYCLES - 1)) cnt[i] <= cnt[i] + 1'b1;
        else begin
          cnt[i]       <= '0;
          btn_level[i] <= btn_s2[i];
          btn_press[i] <= btn_s2[i];
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div        <= '0;
      cpu_clk_en <= 1'b0;
      step_count <= '0;
    end else begin
      div        <= (toggle || mode_s2 || div_wrap) ? '0 : div + 1'b1;
      cpu_clk_en <= !toggle && (mode_s2 ? btn_press[STEP_BTN] : div_wrap);
      step_count <= step_count + 16'(cpu_clk_en);
    end
endmodule
